// File: rtl/pfpu32_addsub_rnd.sv
// ---------------------------------------------------------------------------
// pfpu32_addsub_rnd
// Align, round and pack stage that follows a single-precision add/sub core.
// Two-stage pipeline. Every register loads only while adv_i=1.
//   Stage 1 aligns the 28-bit fraction. A carry shifts it right by one and
//   folds the lost bit into sticky. Otherwise it is normalised by a left
//   shift. The exponent is chosen to match the alignment.
//   Stage 2 rounds using rmode, handles the rounding carry-out, detects
//   overflow and underflow, applies special cases and registers the packed
//   IEEE-754 result together with the flags.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush_i         drops both valid bits (data registers are untouched)
//   adv_i           pipeline advance enable
//   rmode_i         0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf
//   add_*_i         producer fields and special-case qualifiers
//   rdy_o           result valid
//   result_o        packed IEEE-754 single
//   inv_o, ovf_o, unf_o, inx_o
//                   IEEE exception flags
// ---------------------------------------------------------------------------
module pfpu32_addsub_rnd (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        adv_i,
    input  logic [1:0]  rmode_i,
    input  logic        add_rdy_i,
    input  logic        add_sign_i,
    input  logic        add_sub_0_i,
    input  logic [4:0]  add_shl_i,
    input  logic [9:0]  add_exp10shl_i,
    input  logic [9:0]  add_exp10sh0_i,
    input  logic [27:0] add_fract28_i,
    input  logic        add_inv_i,
    input  logic        add_inf_i,
    input  logic        add_snan_i,
    input  logic        add_qnan_i,
    input  logic        add_anan_sign_i,
    output logic        rdy_o,
    output logic [31:0] result_o,
    output logic        inv_o,
    output logic        ovf_o,
    output logic        unf_o,
    output logic        inx_o
);

    // Round-up increment for the selected rounding mode
    function automatic logic round_inc(input logic [1:0] rmode, input logic sign,
                                       input logic g, input logic rs, input logic lsb);
        logic inc;
        case (rmode)
            2'd0:    inc = g & (rs | lsb);
            2'd1:    inc = 1'b0;
            2'd2:    inc = (g | rs) & ~sign;
            2'd3:    inc = (g | rs) & sign;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    // ---------------- stage 1: alignment ----------------
    logic [27:0] fract_shl_s;
    logic [26:0] fract_al_s;
    logic [9:0]  exp_al_s;

    logic        s1_rdy_r;
    logic        s1_sign_r;
    logic        s1_sub_0_r;
    logic [1:0]  s1_rmode_r;
    logic        s1_inv_r;
    logic        s1_inf_r;
    logic        s1_snan_r;
    logic        s1_qnan_r;
    logic        s1_anan_sign_r;
    logic [9:0]  s1_exp10_r;
    logic [26:0] s1_fract_r;

    // Align fraction so the hidden bit lands at [26]; a zero hidden bit means denormal/zero
    always_comb begin
        fract_shl_s = add_fract28_i << add_shl_i;
        if (add_fract28_i[27]) begin
            fract_al_s = {add_fract28_i[27:2], add_fract28_i[1] | add_fract28_i[0]};
            exp_al_s   = add_exp10sh0_i + 10'd1;
        end else begin
            fract_al_s = fract_shl_s[26:0];
            exp_al_s   = add_exp10shl_i;
        end
        if (!fract_al_s[26]) begin
            exp_al_s = 10'd0;
        end else begin
            exp_al_s = exp_al_s;
        end
    end

    // Stage-1 valid bit: reset beats flush, flush beats advance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rdy_r <= 1'b0;
        end else if (flush_i) begin
            s1_rdy_r <= 1'b0;
        end else if (adv_i) begin
            s1_rdy_r <= add_rdy_i;
        end else begin
            s1_rdy_r <= s1_rdy_r;
        end
    end

    // Stage-1 data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign_r      <= 1'b0;
            s1_sub_0_r     <= 1'b0;
            s1_rmode_r     <= 2'd0;
            s1_inv_r       <= 1'b0;
            s1_inf_r       <= 1'b0;
            s1_snan_r      <= 1'b0;
            s1_qnan_r      <= 1'b0;
            s1_anan_sign_r <= 1'b0;
            s1_exp10_r     <= 10'd0;
            s1_fract_r     <= 27'd0;
        end else if (adv_i) begin
            s1_sign_r      <= add_sign_i;
            s1_sub_0_r     <= add_sub_0_i;
            s1_rmode_r     <= rmode_i;
            s1_inv_r       <= add_inv_i;
            s1_inf_r       <= add_inf_i;
            s1_snan_r      <= add_snan_i;
            s1_qnan_r      <= add_qnan_i;
            s1_anan_sign_r <= add_anan_sign_i;
            s1_exp10_r     <= exp_al_s;
            s1_fract_r     <= fract_al_s;
        end else begin
            s1_sign_r      <= s1_sign_r;
            s1_sub_0_r     <= s1_sub_0_r;
            s1_rmode_r     <= s1_rmode_r;
            s1_inv_r       <= s1_inv_r;
            s1_inf_r       <= s1_inf_r;
            s1_snan_r      <= s1_snan_r;
            s1_qnan_r      <= s1_qnan_r;
            s1_anan_sign_r <= s1_anan_sign_r;
            s1_exp10_r     <= s1_exp10_r;
            s1_fract_r     <= s1_fract_r;
        end
    end

    // ---------------- stage 2: rounding and packing ----------------
    logic        inexact_s;
    logic        inc_s;
    logic [24:0] sum25_s;
    logic [23:0] sig24_s;
    logic [9:0]  exp_rnd_s;
    logic        ovf_cond_s;
    logic [31:0] res_s;
    logic        inv_s;
    logic        ovf_s;
    logic        unf_s;
    logic        inx_s;

    assign inexact_s = s1_fract_r[2] | s1_fract_r[1] | s1_fract_r[0];
    assign inc_s     = round_inc(s1_rmode_r, s1_sign_r, s1_fract_r[2],
                                 s1_fract_r[1] | s1_fract_r[0], s1_fract_r[3]);
    assign sum25_s   = {1'b0, s1_fract_r[26:3]} + {24'd0, inc_s};

    // Post-round normalisation: carry-out renormalises, a denormal that gains its hidden bit becomes exp 1
    always_comb begin
        if (sum25_s[24]) begin
            sig24_s   = sum25_s[24:1];
            exp_rnd_s = s1_exp10_r + 10'd1;
        end else if ((s1_exp10_r == 10'd0) && sum25_s[23]) begin
            sig24_s   = sum25_s[23:0];
            exp_rnd_s = 10'd1;
        end else begin
            sig24_s   = sum25_s[23:0];
            exp_rnd_s = s1_exp10_r;
        end
    end

    assign ovf_cond_s = (exp_rnd_s >= 10'd255);

    // Result selection: NaN-generating cases, quiet NaN, infinity, exact zero, overflow, normal
    always_comb begin
        res_s = 32'd0;
        inv_s = 1'b0;
        ovf_s = 1'b0;
        unf_s = 1'b0;
        inx_s = 1'b0;
        if (s1_inv_r || s1_snan_r) begin
            res_s = {s1_anan_sign_r, 8'hFF, 1'b1, 22'd0};
            inv_s = 1'b1;
        end else if (s1_qnan_r) begin
            res_s = {s1_anan_sign_r, 8'hFF, 1'b1, 22'd0};
        end else if (s1_inf_r) begin
            res_s = {s1_sign_r, 8'hFF, 23'd0};
        end else if (s1_sub_0_r) begin
            res_s = {(s1_rmode_r == 2'd3), 31'd0};
        end else if (ovf_cond_s) begin
            ovf_s = 1'b1;
            inx_s = 1'b1;
            if ((s1_rmode_r == 2'd0) ||
                ((s1_rmode_r == 2'd2) && !s1_sign_r) ||
                ((s1_rmode_r == 2'd3) && s1_sign_r)) begin
                res_s = {s1_sign_r, 8'hFF, 23'd0};
            end else begin
                res_s = {s1_sign_r, 31'h7F7FFFFF};
            end
        end else begin
            res_s = {s1_sign_r, exp_rnd_s[7:0], sig24_s[22:0]};
            inx_s = inexact_s;
            unf_s = (exp_rnd_s == 10'd0) && inexact_s;
        end
    end

    // Output valid bit: reset beats flush, flush beats advance
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_o <= 1'b0;
        end else if (flush_i) begin
            rdy_o <= 1'b0;
        end else if (adv_i) begin
            rdy_o <= s1_rdy_r;
        end else begin
            rdy_o <= rdy_o;
        end
    end

    // Output result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result_o <= 32'd0;
            inv_o    <= 1'b0;
            ovf_o    <= 1'b0;
            unf_o    <= 1'b0;
            inx_o    <= 1'b0;
        end else if (adv_i) begin
            result_o <= res_s;
            inv_o    <= inv_s;
            ovf_o    <= ovf_s;
            unf_o    <= unf_s;
            inx_o    <= inx_s;
        end else begin
            result_o <= result_o;
            inv_o    <= inv_o;
            ovf_o    <= ovf_o;
            unf_o    <= unf_o;
            inx_o    <= inx_o;
        end
    end

endmodule

// File: tb/tb_pfpu32_addsub_rnd.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pfpu32_addsub_rnd.
// It applies directed vectors with hand-computed results.
// Observed output tuple: {rdy, result[31:0], inv, ovf, unf, inx}.
// ---------------------------------------------------------------------------
module tb_pfpu32_addsub_rnd;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        adv_i;
    logic [1:0]  rmode_i;
    logic        add_rdy_i;
    logic        add_sign_i;
    logic        add_sub_0_i;
    logic [4:0]  add_shl_i;
    logic [9:0]  add_exp10shl_i;
    logic [9:0]  add_exp10sh0_i;
    logic [27:0] add_fract28_i;
    logic        add_inv_i;
    logic        add_inf_i;
    logic        add_snan_i;
    logic        add_qnan_i;
    logic        add_anan_sign_i;
    logic        rdy_o;
    logic [31:0] result_o;
    logic        inv_o;
    logic        ovf_o;
    logic        unf_o;
    logic        inx_o;

    int checks = 0;
    int errors = 0;

    logic [36:0] obs;
    assign obs = {rdy_o, result_o, inv_o, ovf_o, unf_o, inx_o};

    always #5 clk = ~clk;

    pfpu32_addsub_rnd dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .adv_i(adv_i), .rmode_i(rmode_i),
        .add_rdy_i(add_rdy_i), .add_sign_i(add_sign_i), .add_sub_0_i(add_sub_0_i),
        .add_shl_i(add_shl_i), .add_exp10shl_i(add_exp10shl_i),
        .add_exp10sh0_i(add_exp10sh0_i), .add_fract28_i(add_fract28_i),
        .add_inv_i(add_inv_i), .add_inf_i(add_inf_i), .add_snan_i(add_snan_i),
        .add_qnan_i(add_qnan_i), .add_anan_sign_i(add_anan_sign_i),
        .rdy_o(rdy_o), .result_o(result_o), .inv_o(inv_o), .ovf_o(ovf_o),
        .unf_o(unf_o), .inx_o(inx_o)
    );

    // flags are {inv, ovf, unf, inx}
    typedef struct packed {
        logic        sign;
        logic [1:0]  rm;
        logic [4:0]  shl;
        logic [9:0]  eshl;
        logic [9:0]  esh0;
        logic [27:0] fr;
        logic [31:0] res;
        logic [3:0]  flg;
    } rnd_vec_t;

    localparam int NRND = 16;
    localparam rnd_vec_t RND_VECS [NRND] = '{
        '{1'b0, 2'd0, 5'd0, 10'd0,   10'd127, 28'h8000000, 32'h40000000, 4'b0000},
        '{1'b0, 2'd0, 5'd0, 10'd127, 10'd0,   28'h4000004, 32'h3F800000, 4'b0001},
        '{1'b0, 2'd0, 5'd0, 10'd127, 10'd0,   28'h400000C, 32'h3F800002, 4'b0001},
        '{1'b0, 2'd2, 5'd0, 10'd127, 10'd0,   28'h4000002, 32'h3F800001, 4'b0001},
        '{1'b1, 2'd3, 5'd0, 10'd127, 10'd0,   28'h4000002, 32'hBF800001, 4'b0001},
        '{1'b0, 2'd3, 5'd0, 10'd127, 10'd0,   28'h4000002, 32'h3F800000, 4'b0001},
        '{1'b0, 2'd1, 5'd0, 10'd127, 10'd0,   28'h400000C, 32'h3F800001, 4'b0001},
        '{1'b0, 2'd0, 5'd5, 10'd100, 10'd0,   28'h0200000, 32'h32000000, 4'b0000},
        '{1'b0, 2'd0, 5'd0, 10'd0,   10'd0,   28'h0000010, 32'h00000002, 4'b0000},
        '{1'b0, 2'd0, 5'd0, 10'd0,   10'd0,   28'h000001C, 32'h00000004, 4'b0011},
        '{1'b0, 2'd0, 5'd0, 10'd0,   10'd0,   28'h3FFFFFC, 32'h00800000, 4'b0001},
        '{1'b0, 2'd0, 5'd0, 10'd0,   10'd127, 28'h8000003, 32'h40000000, 4'b0001},
        '{1'b0, 2'd0, 5'd0, 10'd254, 10'd0,   28'h7FFFFFC, 32'h7F800000, 4'b0101},
        '{1'b0, 2'd1, 5'd0, 10'd254, 10'd0,   28'h7FFFFFC, 32'h7F7FFFFF, 4'b0001},
        '{1'b1, 2'd2, 5'd0, 10'd255, 10'd0,   28'h7FFFFFC, 32'hFF7FFFFF, 4'b0101},
        '{1'b1, 2'd3, 5'd0, 10'd255, 10'd0,   28'h4000000, 32'hFF800000, 4'b0101}
    };

    typedef struct packed {
        logic        inv;
        logic        snan;
        logic        qnan;
        logic        inf;
        logic        anan;
        logic        sign;
        logic        sub0;
        logic [1:0]  rm;
        logic [31:0] res;
        logic [3:0]  flg;
    } spc_vec_t;

    localparam int NSPC = 9;
    localparam spc_vec_t SPC_VECS [NSPC] = '{
        '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h7FC00000, 4'b1000},
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hFFC00000, 4'b1000},
        '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h7FC00000, 4'b0000},
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hFF800000, 4'b0000},
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h7FC00000, 4'b1000},
        '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hFFC00000, 4'b0000},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h80000000, 4'b0000},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h00000000, 4'b0000},
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h7F800000, 4'b0000}
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rnd(input rnd_vec_t v);
        add_rdy_i       = 1'b1;
        add_sign_i      = v.sign;
        rmode_i         = v.rm;
        add_shl_i       = v.shl;
        add_exp10shl_i  = v.eshl;
        add_exp10sh0_i  = v.esh0;
        add_fract28_i   = v.fr;
        add_sub_0_i     = 1'b0;
        add_inv_i       = 1'b0;
        add_inf_i       = 1'b0;
        add_snan_i      = 1'b0;
        add_qnan_i      = 1'b0;
        add_anan_sign_i = 1'b0;
    endtask

    // two advance pulses: input captured, then result registered
    task automatic pump2();
        adv_i = 1'b1;
        step();
        add_rdy_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; adv_i = 1'b1; rmode_i = 2'd0;
        apply_rnd(RND_VECS[1]);
        step(); step();
        if (obs !== 37'd0) begin
            $display("FAIL reset got %h expected %h", obs, 37'd0);
            errors++;
        end
        checks++;
        rst = 1'b0;
        add_rdy_i = 1'b0;
        step();
    endtask

    task automatic test_round();
        for (int i = 0; i < NRND; i++) begin
            apply_rnd(RND_VECS[i]);
            pump2();
            if (obs !== {1'b1, RND_VECS[i].res, RND_VECS[i].flg}) begin
                $display("FAIL round[%0d] got %h expected %h", i, obs,
                         {1'b1, RND_VECS[i].res, RND_VECS[i].flg});
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_specials();
        for (int i = 0; i < NSPC; i++) begin
            apply_rnd(RND_VECS[0]);
            add_fract28_i   = 28'd0;
            add_exp10sh0_i  = 10'd0;
            add_inv_i       = SPC_VECS[i].inv;
            add_snan_i      = SPC_VECS[i].snan;
            add_qnan_i      = SPC_VECS[i].qnan;
            add_inf_i       = SPC_VECS[i].inf;
            add_anan_sign_i = SPC_VECS[i].anan;
            add_sign_i      = SPC_VECS[i].sign;
            add_sub_0_i     = SPC_VECS[i].sub0;
            rmode_i         = SPC_VECS[i].rm;
            pump2();
            if (obs !== {1'b1, SPC_VECS[i].res, SPC_VECS[i].flg}) begin
                $display("FAIL special[%0d] got %h expected %h", i, obs,
                         {1'b1, SPC_VECS[i].res, SPC_VECS[i].flg});
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back_stall_flush();
        logic [36:0] exp_a;
        logic [36:0] exp_b;
        exp_a = {1'b1, RND_VECS[2].res, RND_VECS[2].flg};
        exp_b = {1'b1, RND_VECS[0].res, RND_VECS[0].flg};
        adv_i = 1'b1;
        apply_rnd(RND_VECS[2]);
        step();
        apply_rnd(RND_VECS[0]);
        step();
        if (obs !== exp_a) begin
            $display("FAIL b2b_first got %h expected %h", obs, exp_a);
            errors++;
        end
        checks++;
        // stall with a different vector on the inputs: both stages must hold
        adv_i = 1'b0;
        apply_rnd(RND_VECS[12]);
        for (int c = 0; c < 3; c++) begin
            step();
            if (obs !== exp_a) begin
                $display("FAIL stall_hold[%0d] got %h expected %h", c, obs, exp_a);
                errors++;
            end
            checks++;
        end
        adv_i = 1'b1;
        add_rdy_i = 1'b0;
        step();
        if (obs !== exp_b) begin
            $display("FAIL after_stall got %h expected %h", obs, exp_b);
            errors++;
        end
        checks++;
        // refill, then flush with both stages holding valids
        apply_rnd(RND_VECS[2]);
        step();
        apply_rnd(RND_VECS[0]);
        step();
        adv_i = 1'b0;
        add_rdy_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        if (rdy_o !== 1'b0) begin
            $display("FAIL flush_rdy got %b expected %b", rdy_o, 1'b0);
            errors++;
        end
        checks++;
        adv_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            if (rdy_o !== 1'b0) begin
                $display("FAIL flush_no_reemit[%0d] got %b expected %b", c, rdy_o, 1'b0);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        logic [36:0] exp_c;
        exp_c = {1'b1, RND_VECS[3].res, RND_VECS[3].flg};
        adv_i = 1'b1;
        apply_rnd(RND_VECS[2]);
        step();
        apply_rnd(RND_VECS[0]);
        step();
        rst = 1'b1;
        add_rdy_i = 1'b0;
        step();
        rst = 1'b0;
        if (obs !== 37'd0) begin
            $display("FAIL reset_mid got %h expected %h", obs, 37'd0);
            errors++;
        end
        checks++;
        for (int c = 0; c < 2; c++) begin
            step();
            if (rdy_o !== 1'b0) begin
                $display("FAIL reset_no_stale[%0d] got %b expected %b", c, rdy_o, 1'b0);
                errors++;
            end
            checks++;
        end
        apply_rnd(RND_VECS[3]);
        pump2();
        if (obs !== exp_c) begin
            $display("FAIL reset_recover got %h expected %h", obs, exp_c);
            errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_round();
        test_specials();
        test_back_to_back_stall_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
